// File: rtl/popcount_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_arbiter_if
//  Description : Handshake bundle between two word requesters, one result
//                consumer and the popcount_arbiter.
//                  req0_*  : requester 0 valid/ready word channel
//                  req1_*  : requester 1 valid/ready word channel
//                  resp_*  : single-entry result channel (id + ones count)
//                master = requesters/consumer side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface popcount_arbiter_if;
  logic        req0_valid;
  logic [11:0] req0_bits;
  logic        req0_ready;
  logic        req1_valid;
  logic [11:0] req1_bits;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_id;
  logic [3:0]  resp_count;
  logic        resp_ready;

  modport master (
    output req0_valid, req0_bits, input req0_ready,
    output req1_valid, req1_bits, input req1_ready,
    input  resp_valid, resp_id, resp_count,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_bits, output req0_ready,
    input  req1_valid, req1_bits, output req1_ready,
    output resp_valid, resp_id, resp_count,
    input  resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/popcount_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : LUT_12bit_1s
//  Description : Combinational ones counter for a 12-bit word.
//                  bits  : input word
//                  count : number of set bits, 0..12
//  Revision    : 1.0 - initial release
// ============================================================================
module LUT_12bit_1s (
  input  logic [11:0] bits,
  output logic [3:0]  count
);
  logic [3:0] w_acc;

  always_comb begin
    w_acc = 4'd0;
    for (int i = 0; i < 12; i++) begin
      w_acc = w_acc + {3'b000, bits[i]};
    end
  end

  assign count = w_acc;
endmodule

// ============================================================================
//  Module      : popcount_arbiter
//  Description : Round-robin sharing of one 12-bit ones counter between two
//                valid/ready requesters. Results go to a single-entry output
//                buffer tagged with the requester id; a saturating running
//                total of ones is kept per requester.
//                  clk, rst      : clock, synchronous active-high reset
//                  bus (slave)   : req0/req1 word channels, resp channel
//                  clr_totals    : clear both running totals
//                  total0/total1 : per-requester running totals (TOT_W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_arbiter #(
  parameter int TOT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  popcount_arbiter_if.slave bus,
  input  logic              clr_totals,
  output logic [TOT_W-1:0]  total0,
  output logic [TOT_W-1:0]  total1
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic             r_id;
  logic [3:0]       r_count;
  logic             r_prio;
  logic [TOT_W-1:0] r_total0;
  logic [TOT_W-1:0] r_total1;

  logic             w_slot_free;
  logic             w_both;
  logic             w_grant;
  logic             w_gnt_id;
  logic [11:0]      w_bits;
  logic [3:0]       w_count;
  logic [TOT_W-1:0] w_acc_sel;
  logic [TOT_W:0]   w_sum;
  logic [TOT_W-1:0] w_acc_next;

  // The buffer can take a new word when empty or when it is being drained
  // in this same cycle.
  assign w_slot_free = (r_state == ST_EMPTY) || bus.resp_ready;
  assign w_both      = bus.req0_valid && bus.req1_valid;

  // Gating with rst keeps both readies low while in reset, so a requester
  // never believes a word was taken that the reset then discards.
  assign w_grant  = !rst && w_slot_free && (bus.req0_valid || bus.req1_valid);

  // Contention resolved by the pointer; otherwise the lone valid requester.
  assign w_gnt_id = w_both ? r_prio : !bus.req0_valid;

  assign bus.req0_ready = w_grant && !w_gnt_id;
  assign bus.req1_ready = w_grant &&  w_gnt_id;

  assign w_bits = w_gnt_id ? bus.req1_bits : bus.req0_bits;

  LUT_12bit_1s u_ones (
    .bits  (w_bits),
    .count (w_count)
  );

  // Only one total can change per cycle, so a single adder is shared.
  // The extra MSB of w_sum is the overflow flag used for saturation.
  assign w_acc_sel  = w_gnt_id ? r_total1 : r_total0;
  assign w_sum      = {1'b0, w_acc_sel} + (TOT_W+1)'(w_count);
  assign w_acc_next = w_sum[TOT_W] ? {TOT_W{1'b1}} : w_sum[TOT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_id     <= 1'b0;
      r_count  <= 4'd0;
      r_prio   <= 1'b0;
      r_total0 <= '0;
      r_total1 <= '0;
    end else begin
      // Output buffer: a grant always (re)fills it; a drain without a
      // refill empties it while id/count keep their last values.
      if (w_grant) begin
        r_state <= ST_FULL;
        r_id    <= w_gnt_id;
        r_count <= w_count;
      end else if (bus.resp_ready) begin
        r_state <= ST_EMPTY;
      end

      // Pointer moves only on a contended grant, to the loser.
      if (w_grant && w_both) begin
        r_prio <= ~w_gnt_id;
      end

      // Clearing wins over a same-cycle accumulation.
      if (clr_totals) begin
        r_total0 <= '0;
        r_total1 <= '0;
      end else if (w_grant) begin
        if (w_gnt_id) begin
          r_total1 <= w_acc_next;
        end else begin
          r_total0 <= w_acc_next;
        end
      end
    end
  end

  assign bus.resp_valid = (r_state == ST_FULL);
  assign bus.resp_id    = r_id;
  assign bus.resp_count = r_count;
  assign total0         = r_total0;
  assign total1         = r_total1;
endmodule
`default_nettype wire

// File: tb/tb_popcount_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_arbiter
//  Description : Scoreboard bench for popcount_arbiter. Stimulus pushes the
//                hand-computed {id,count} of each accepted word; a monitor
//                pops and compares whenever a result is consumed.
//                A second instance with TOT_W=4 exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_totals = 1'b0;
  logic        clr_b = 1'b0;
  logic [15:0] total0, total1;
  logic [3:0]  total0b, total1b;

  popcount_arbiter_if bus ();
  popcount_arbiter_if busb ();

  popcount_arbiter #(.TOT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .clr_totals (clr_totals),
    .total0     (total0),
    .total1     (total1)
  );

  popcount_arbiter #(.TOT_W(4)) u_dut_sat (
    .clk        (clk),
    .rst        (rst),
    .bus        (busb.slave),
    .clr_totals (clr_b),
    .total0     (total0b),
    .total1     (total1b)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic push(input int id, input int cnt);
    logic [4:0] e;
    e = {id[0], cnt[3:0]};
    exp_q.push_back(e);
  endtask

  task automatic idle;
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    busb.req0_valid = 1'b0;
    busb.req1_valid = 1'b0;
  endtask

  // Monitor: a result is consumed when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got id=%0d count=%0d expected no result",
                 bus.resp_id, bus.resp_count);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id", int'(bus.resp_id), int'(mon_e[4]));
        chk("resp_count", int'(bus.resp_count), int'(mon_e[3:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.req0_bits   = 12'h000;
    bus.req1_bits   = 12'h000;
    bus.resp_ready  = 1'b0;
    busb.req0_bits  = 12'h000;
    busb.req1_bits  = 12'h000;
    busb.resp_ready = 1'b0;
    tick();
    tick();

    // ---- reset values, no acceptance during reset
    bus.req0_valid = 1'b1;
    bus.req0_bits  = 12'hFFF;
    bus.resp_ready = 1'b1;
    smp();
    chk("rst_req0_ready", int'(bus.req0_ready), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_resp_id", int'(bus.resp_id), 0);
    chk("rst_resp_count", int'(bus.resp_count), 0);
    chk("rst_total0", int'(total0), 0);
    chk("rst_total1", int'(total1), 0);

    // ---- single word 0xFFF from req0
    tick();
    rst = 1'b0;
    smp();
    chk("t1_req0_ready", int'(bus.req0_ready), 1);
    chk("t1_req1_ready", int'(bus.req1_ready), 0);
    push(0, 12);
    tick();
    idle();
    smp();
    chk("t1_resp_valid", int'(bus.resp_valid), 1);
    chk("t1_total0", int'(total0), 12);

    // ---- both valid from reset: alternate 0,1,0,1 with counts 7,5,7,5
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_bits  = 12'b010110101101;
    bus.req1_valid = 1'b1;
    bus.req1_bits  = 12'b100001011100;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t2_req0_ready", int'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("t2_req1_ready", int'(bus.req1_ready), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) push(0, 7);
      else            push(1, 5);
      tick();
    end
    idle();
    smp();
    chk("t2_total0", int'(total0), 14);
    chk("t2_total1", int'(total1), 10);
    tick();

    // ---- backpressure: buffer full with {0,4}, req1 waits three cycles
    bus.req0_valid = 1'b1;
    bus.req0_bits  = 12'h00F;
    bus.resp_ready = 1'b0;
    smp();
    chk("t3_req0_ready", int'(bus.req0_ready), 1);
    push(0, 4);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_bits  = 12'h007;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t3_hold_req1_ready", int'(bus.req1_ready), 0);
      chk("t3_hold_valid", int'(bus.resp_valid), 1);
      chk("t3_hold_id", int'(bus.resp_id), 0);
      chk("t3_hold_count", int'(bus.resp_count), 4);
      tick();
    end
    bus.resp_ready = 1'b1;
    smp();
    chk("t3_req1_ready", int'(bus.req1_ready), 1);
    push(1, 3);
    tick();
    idle();
    smp();
    chk("t3_total0", int'(total0), 18);
    chk("t3_total1", int'(total1), 13);
    tick();

    // ---- lone req1 grants leave the pointer alone; req0 then wins
    bus.req1_valid = 1'b1;
    bus.req1_bits  = 12'h003;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t4_lone_req1_ready", int'(bus.req1_ready), 1);
      push(1, 2);
      tick();
    end
    bus.req0_valid = 1'b1;
    bus.req0_bits  = 12'h001;
    smp();
    chk("t4_both_req0_ready", int'(bus.req0_ready), 1);
    chk("t4_both_req1_ready", int'(bus.req1_ready), 0);
    push(0, 1);
    tick();
    smp();
    chk("t4_next_req1_ready", int'(bus.req1_ready), 1);
    push(1, 2);
    tick();
    idle();
    smp();
    chk("t4_total0", int'(total0), 19);
    chk("t4_total1", int'(total1), 21);
    tick();

    // ---- clear totals in the same cycle as a 0xFFF grant
    bus.req0_valid = 1'b1;
    bus.req0_bits  = 12'hFFF;
    clr_totals     = 1'b1;
    smp();
    chk("t5_req0_ready", int'(bus.req0_ready), 1);
    push(0, 12);
    tick();
    idle();
    clr_totals = 1'b0;
    smp();
    chk("t5_total0", int'(total0), 0);
    chk("t5_total1", int'(total1), 0);
    tick();

    // ---- reset while a result is buffered; pointer returns to req0
    bus.req0_valid = 1'b1;
    bus.req0_bits  = 12'h001;
    bus.req1_valid = 1'b1;
    bus.req1_bits  = 12'hFFF;
    smp();
    chk("t7_req0_ready", int'(bus.req0_ready), 1);
    push(0, 1);
    tick();
    bus.req0_valid = 1'b0;
    smp();
    chk("t7_lone_req1_ready", int'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    smp();
    chk("t7_pre_rst_valid", int'(bus.resp_valid), 1);
    chk("t7_pre_rst_id", int'(bus.resp_id), 1);
    chk("t7_rst_req0_ready", int'(bus.req0_ready), 0);
    tick();
    rst = 1'b0;
    idle();
    smp();
    chk("t7_resp_valid", int'(bus.resp_valid), 0);
    chk("t7_resp_id", int'(bus.resp_id), 0);
    chk("t7_resp_count", int'(bus.resp_count), 0);
    chk("t7_total0", int'(total0), 0);
    chk("t7_total1", int'(total1), 0);
    tick();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    smp();
    chk("t7_prio_req0_ready", int'(bus.req0_ready), 1);
    chk("t7_prio_req1_ready", int'(bus.req1_ready), 0);
    push(0, 1);
    tick();
    idle();
    smp();
    tick();

    // ---- TOT_W=4 saturation: 12 then 15, holding at 15
    busb.req0_valid = 1'b1;
    busb.req0_bits  = 12'hFFF;
    busb.resp_ready = 1'b1;
    smp();
    chk("t6_req0_ready", int'(busb.req0_ready), 1);
    chk("t6_total0_start", int'(total0b), 0);
    tick();
    smp();
    chk("t6_total0_first", int'(total0b), 12);
    chk("t6_resp_count", int'(busb.resp_count), 12);
    tick();
    smp();
    chk("t6_total0_sat", int'(total0b), 15);
    tick();
    busb.req0_valid = 1'b0;
    smp();
    chk("t6_total0_hold", int'(total0b), 15);
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/popcount_arbiter.md
# popcount_arbiter

Round-robin controller that shares one 12-bit ones-counter (`LUT_12bit_1s`, ports `bits`/`count`, instantiated internally) between two requesters. Each requester presents 12-bit words over a valid/ready handshake. The block grants one word per cycle to the counter and registers the 4-bit result with the requester ID into a single-entry output buffer. It also keeps a saturating running total of ones per requester. It sits between producer logic and any consumer of bit-population statistics.

## Interface
Parameters:
- `TOT_W`, default 16: width of each per-requester running total.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has a word.
- `req0_bits` input 12: requester 0 word.
- `req0_ready` output 1: requester 0 word accepted this cycle (combinational).
- `req1_valid` input 1: requester 1 has a word.
- `req1_bits` input 12: requester 1 word.
- `req1_ready` output 1: requester 1 word accepted this cycle (combinational).
- `resp_valid` output 1: output buffer holds a result.
- `resp_id` output 1: requester that produced the buffered result.
- `resp_count` output 4: ones count of the buffered word, 0..12.
- `resp_ready` input 1: consumer takes the result this cycle.
- `clr_totals` input 1: clear both running totals.
- `total0` output TOT_W: ones accumulated from requester 0.
- `total1` output TOT_W: ones accumulated from requester 1.

## Operation
- `slot_free = !resp_valid || resp_ready`. The buffer can be drained and refilled in the same cycle.
- Grant logic is combinational and only active when `slot_free`:
  - One requester valid: grant it.
  - Both valid: grant the requester selected by the priority pointer `prio`.
- `reqN_ready` is high only for the granted requester. At most one ready is high per cycle.
- `prio` toggles only when both requesters are valid and a grant is issued. It then points to the requester that was not granted. A lone grant leaves `prio` unchanged.
- The granted word's bits drive the counter `bits`. On the edge:
  - `resp_count` is loaded with `count`.
  - `resp_id` is loaded with the granted index.
  - `resp_valid` is set to 1.
- `resp_ready` with no grant: `resp_valid` is cleared to 0. `resp_id` and `resp_count` hold their last values.
- Without `resp_ready`: the buffer holds and no grant is issued (backpressure). A requester with `valid` high must hold `bits` stable until it sees `ready`.
- Totals:
  - On each grant, the granted requester's total is updated as `total += count`, saturating at 2^TOT_W−1.
  - `clr_totals` sets both totals to 0. It takes precedence over a same-cycle accumulation.
  - The word is still answered normally on `resp_*`.
- States:
  - EMPTY (`resp_valid=0`): goes to FULL on a grant.
  - FULL (`resp_valid=1`): goes to EMPTY on `resp_ready` without a grant, or stays FULL on `resp_ready` with a grant.

## Timing
- Reset values: `resp_valid=0`, `resp_id=0`, `resp_count=0`, `total0=0`, `total1=0`, `prio=0` (requester 0 first).
- `reqN_ready` is low during the reset cycle.
- Latency: a word accepted at edge N appears on `resp_*` after edge N, and is consumable in cycle N+1.
- Throughput: one word per cycle while `resp_ready` is held high.
- Totals update at the same edge as the grant.
- Reset mid-operation discards any buffered result. Words presented during reset are not accepted.

## Test plan
- Reset, then `req0_valid` with `bits=12'hFFF` and `resp_ready=1`:
  - `req0_ready=1` in the same cycle.
  - Next cycle: `resp_valid=1`, `resp_id=0`, `resp_count=12`, `total0=12`.
- Both valid from reset (`req0_bits=12'b010110101101`, `req1_bits=12'b100001011100`), `resp_ready=1`, held for 4 cycles:
  - Grants alternate 0,1,0,1.
  - Counts are 7,5,7,5.
  - `total0=14`, `total1=10`.
- `resp_ready=0` with the buffer full and `req1_valid=1`:
  - `req1_ready` stays 0 and `resp_*` hold for 3 cycles.
  - Raising `resp_ready` accepts req1 in that cycle.
- Only req1 valid for 3 words, then both valid:
  - `prio` is unchanged by the lone grants.
  - req0 wins first.
- `clr_totals` in the same cycle as a grant of 12'hFFF to req0:
  - `total0=0`.
  - `resp_count=12` is still delivered.
- `TOT_W=4`, repeated 12'hFFF to req0:
  - `total0` reads 12, then saturates at 15 and stays at 15.
- `rst` asserted while `resp_valid=1`:
  - Next cycle all outputs are 0 and `prio=0`.
